// File: rtl/muldiv_pkg.sv
// Shared state encoding, M-extension func3 codes and iteration constants for the
// execute-stage multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Wide enough to hold the full-width iteration count (64).
  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] STEPS_WORD = 7'd32;

  // rs1 is treated as two's complement for these operations.
  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as two's complement for these operations.
  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: W-variant extension, magnitudes, sign flags
// and detection of the divide cases that bypass the iterative datapath.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]            func3,
  input  logic                  word,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] a_mag,
  output logic [DATA_WIDTH-1:0] b_mag,
  output logic                  res_neg,
  output logic                  rem_neg,
  output logic                  div_zero,
  output logic                  div_ovf
);

  logic [DATA_WIDTH-1:0] a_ext;
  logic [DATA_WIDTH-1:0] b_ext;
  logic [DATA_WIDTH-1:0] min_val;
  logic                  a_sgn;
  logic                  b_sgn;
  logic                  a_neg;
  logic                  b_neg;

  // Illegal W-variant high multiplies collapse to MULW; then extend, take magnitudes and flag special divides.
  always_comb begin
    op = (word && !func3[2]) ? F3_MUL : func3;
    a_sgn = rs1_is_signed(op);
    b_sgn = rs2_is_signed(op);
    if (word) begin
      a_ext   = {{(DATA_WIDTH-32){a_sgn & rs1_data[31]}}, rs1_data[31:0]};
      b_ext   = {{(DATA_WIDTH-32){b_sgn & rs2_data[31]}}, rs2_data[31:0]};
      min_val = {{(DATA_WIDTH-32){1'b1}}, 32'h8000_0000};
    end else begin
      a_ext   = rs1_data;
      b_ext   = rs2_data;
      min_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
    a_neg    = a_sgn & a_ext[DATA_WIDTH-1];
    b_neg    = b_sgn & b_ext[DATA_WIDTH-1];
    a_mag    = a_neg ? (-a_ext) : a_ext;
    b_mag    = b_neg ? (-b_ext) : b_ext;
    res_neg  = a_neg ^ b_neg;
    rem_neg  = a_neg;
    div_zero = op[2] & (b_ext == '0);
    div_ovf  = op[2] & ~op[0] & (a_ext == min_val) & (b_ext == '1);
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV64 M-extension unit for the execute stage: radix-2 shift-add
// multiply and restoring divide on magnitudes, with one-cycle fast paths for
// divide-by-zero and signed overflow. Stalls the front of the pipe while busy.
module execute_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [2:0]            func3_i,
  input  logic                  word_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_W-1:0] STEPS_FULL = CNT_W'(DATA_WIDTH);

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [2:0]     op_q, op_d;
  logic           word_q, word_d;
  logic           res_neg_q, res_neg_d;
  logic           rem_neg_q, rem_neg_d;

  logic [2:0]     p_op;
  logic [W-1:0]   p_a_mag;
  logic [W-1:0]   p_b_mag;
  logic           p_res_neg;
  logic           p_rem_neg;
  logic           p_div_zero;
  logic           p_div_ovf;

  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W-1:0]   div_diff;
  logic           div_ge;

  logic [2*W-1:0] mul_mag;
  logic [2*W-1:0] mul_val;
  logic [W-1:0]   quo_val;
  logic [W-1:0]   rem_val;
  logic [W-1:0]   full_val;
  logic [W-1:0]   final_val;

  muldiv_operand_prep #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_prep (
    .func3    (func3_i),
    .word     (word_i),
    .rs1_data (rs1_data_i),
    .rs2_data (rs2_data_i),
    .op       (p_op),
    .a_mag    (p_a_mag),
    .b_mag    (p_b_mag),
    .res_neg  (p_res_neg),
    .rem_neg  (p_rem_neg),
    .div_zero (p_div_zero),
    .div_ovf  (p_div_ovf)
  );

  // One radix-2 step: {acc,lo} shifts right through the adder for multiply; {acc,lo} shifts left with trial subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    div_shift = {acc_q, lo_q[W-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[W-1:0] - opnd_q;
  end

  // Next-state and datapath-load logic; flush wins over everything else.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    word_d    = word_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_d      = p_op;
            word_d    = word_i;
            res_neg_d = p_res_neg;
            rem_neg_d = p_rem_neg;
            cnt_d     = word_i ? STEPS_WORD : STEPS_FULL;
            opnd_d    = p_b_mag;
            acc_d     = '0;
            if (!p_op[2]) begin
              state_d = ST_MUL;
              lo_d    = p_b_mag;
              opnd_d  = p_a_mag;
            end else if (p_div_zero) begin
              state_d   = ST_DONE;
              cnt_d     = '0;
              lo_d      = '1;
              acc_d     = p_a_mag;
              res_neg_d = 1'b0;
            end else if (p_div_ovf) begin
              state_d   = ST_DONE;
              cnt_d     = '0;
              lo_d      = p_a_mag;
              res_neg_d = 1'b0;
              rem_neg_d = 1'b0;
            end else begin
              state_d = ST_DIV;
              lo_d    = word_i ? (p_a_mag << 32) : p_a_mag;
            end
          end
        end
        ST_MUL: begin
          acc_d = mul_sum[W:1];
          lo_d  = {mul_sum[0], lo_q[W-1:1]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DIV: begin
          acc_d = div_ge ? div_diff : div_shift[W-1:0];
          lo_d  = {lo_q[W-2:0], div_ge};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      word_q    <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      word_q    <= word_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  // Apply signs to the magnitude results and pick the field the operation asked for; a W-variant product sits 32 bits up.
  always_comb begin
    mul_mag = word_q ? ({acc_q, lo_q} >> 32) : {acc_q, lo_q};
    mul_val = res_neg_q ? (-mul_mag) : mul_mag;
    quo_val = res_neg_q ? (-lo_q) : lo_q;
    rem_val = rem_neg_q ? (-acc_q) : acc_q;
    case (op_q)
      F3_MUL:                       full_val = mul_val[W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: full_val = mul_val[2*W-1:W];
      F3_DIV, F3_DIVU:              full_val = quo_val;
      F3_REM, F3_REMU:              full_val = rem_val;
      default:                      full_val = '0;
    endcase
    final_val = word_q ? {{(W-32){full_val[31]}}, full_val[31:0]} : full_val;
  end

  // Pipeline handshake: hold the front end while accepting or iterating, never while a flush is in progress.
  always_comb begin
    stall_o  = (((state_q == ST_IDLE) & start_i) | (state_q == ST_MUL) | (state_q == ST_DIV)) & ~flush_i;
    done_o   = (state_q == ST_DONE);
    result_o = (state_q == ST_DONE) ? final_val : '0;
  end

endmodule

// File: doc/execute_muldiv_unit.md
EXECUTE_MULDIV_UNIT -- requirements
Module: execute_muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 64, operand/result width.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 arst_i  in  1  reset, asynchronous, active-high.
REQ-004 start_i  in  1  M-extension instruction valid in execute stage this cycle.
REQ-005 flush_i  in  1  kill in-flight operation (execute flush).
REQ-006 func3_i  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 word_i  in  1  RV64 W-variant (MULW, DIVW, DIVUW, REMW, REMUW).
REQ-008 rs1_data_i  in  DATA_WIDTH  forwarded operand A.
REQ-009 rs2_data_i  in  DATA_WIDTH  forwarded operand B.
REQ-010 stall_o  out  1  hold fetch/decode/execute pipeline registers.
REQ-011 done_o  out  1  one-cycle pulse, result_o valid.
REQ-012 result_o  out  DATA_WIDTH  final result; 0 when done_o low.

Function
REQ-013 States IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-014 IDLE: start_i with func3_i[2]=0 -> MUL; func3_i[2]=1 -> DIV, unless fast path (REQ-020/021) -> DONE.
REQ-015 Operands, func3_i, word_i latched on the accepting cycle; later input changes ignored until IDLE.
REQ-016 Iteration counter N = 64 (word_i=0) or 32 (word_i=1); one radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes.
REQ-017 MUL/DIV -> DONE after the Nth step; DONE -> IDLE unconditionally next cycle; done_o high only in DONE.
REQ-018 Latency: done_o high exactly N+1 cycles after accepting cycle (65 or 33); fast path: 1 cycle.
REQ-019 Signedness: MUL/MULH/DIV/REM signed both; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; result negated at end: product if signs differ, quotient if signs differ, remainder takes dividend sign.
REQ-020 Divide by zero: quotient all-ones, remainder = dividend (width per word_i); fast path.
REQ-021 Signed overflow (most-negative / -1): quotient = dividend, remainder 0; fast path.
REQ-022 MUL returns low DATA_WIDTH bits of 128-bit product; MULH* return high DATA_WIDTH bits.
REQ-023 word_i=1: operands = low 32 bits, sign- or zero-extended per op; 32-bit result sign-extended from bit 31 to 64 (DIVUW/REMUW included).
REQ-024 word_i=1 with func3_i in {001,010,011} illegal; treated as MULW (no trap generated here).
REQ-025 stall_o = (IDLE & start_i) | MUL | DIV; low in DONE so the pipeline advances with result_o.
REQ-026 start_i while MUL/DIV/DONE ignored; no queueing.
REQ-027 flush_i in any state -> IDLE next cycle, no done_o; flush_i overrides start_i in the same cycle.
REQ-028 flush_i combinationally gates stall_o low.

Reset
REQ-029 arst_i: state IDLE, counter 0, all datapath registers 0, stall_o 0, done_o 0, result_o 0.
REQ-030 arst_i mid-operation discards the operation; no done_o after release.

Structure
REQ-031 Shared package muldiv_pkg: state enum, func3 constants, counter width constant.
REQ-032 Single sub-module muldiv_operand_prep (combinational abs/extend/sign flags); sequencing in top.

Verification
REQ-033 MUL 7 x -3 (word_i=0) -> done_o on cycle 65, result 0xFFFF_FFFF_FFFF_FFEB; stall_o high cycles 0-64.
REQ-034 MULHU 0xFFFF_FFFF_FFFF_FFFF x 2 -> result 0x1; MULH same -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-035 DIV -7 / 2 -> -3; REM -7 / 2 -> -1; DIVU 100 / 0 -> all-ones, done_o after 1 cycle.
REQ-036 DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, 1 cycle; DIVW 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000.
REQ-037 DIVUW 0xFFFF_FFFF / 1 -> 0xFFFF_FFFF_FFFF_FFFF, done_o on cycle 33.
REQ-038 flush_i at cycle 10 of DIV -> IDLE cycle 11, no done_o, stall_o low; new start_i accepted; arst_i mid-MUL -> all outputs 0.
